// File: rtl/misao_mem_responder_if.sv
// misao_mem_responder_if: nibble bus between MISA-O core/host and memory responder
interface misao_mem_responder_if #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 12
);
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_rw;
  logic [3:0]            mem_data_out;
  logic [3:0]            mem_data_in;
  logic                  mem_enable_read;
  logic                  mem_enable_write;
  logic                  host_we;
  logic [DEPTH_LOG2-1:0] host_addr;
  logic [3:0]            host_wdata;
  logic                  busy;
  modport master (
    output mem_addr, mem_rw, mem_data_out, host_we, host_addr, host_wdata,
    input  mem_data_in, mem_enable_read, mem_enable_write, busy
  );
  modport slave (
    input  mem_addr, mem_rw, mem_data_out, host_we, host_addr, host_wdata,
    output mem_data_in, mem_enable_read, mem_enable_write, busy
  );
endinterface

// File: rtl/misao_mem_responder.sv
// misao_mem_responder: wait-state paced nibble RAM responder for the MISA-O core
module misao_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 0
) (
  input logic clk,
  input logic rst,
  misao_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK_RD, S_ACK_WR} state_t;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  state_t                r_state, w_next, w_ack;
  logic [DEPTH_LOG2-1:0] r_a_q, w_rd_addr;
  logic                  r_rw_q, w_rw;
  logic [3:0]            r_wait_cnt, r_data_in;
  logic [3:0]            r_ram [2**DEPTH_LOG2];
  // next state; in IDLE the live request is used since it is being captured this edge
  always_comb begin
    w_rw      = (r_state == S_IDLE) ? bus.mem_rw : r_rw_q;
    w_rd_addr = (r_state == S_IDLE) ? bus.mem_addr[DEPTH_LOG2-1:0] : r_a_q;
    w_ack     = w_rw ? S_ACK_RD : S_ACK_WR;
    w_next    = (r_state == S_IDLE) ? ((WAIT_STATES > 0) ? S_WAIT : w_ack) :
                (r_state == S_WAIT) ? ((r_wait_cnt == 4'd0) ? w_ack : S_WAIT) : S_IDLE;
  end
  // state, request latch, wait counter and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_data_in  <= 4'h0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_a_q      <= bus.mem_addr[DEPTH_LOG2-1:0];
        r_rw_q     <= bus.mem_rw;
        r_wait_cnt <= WS_M1;
      end
      if (r_state == S_WAIT && r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
      if (w_next == S_ACK_RD) r_data_in <= r_ram[w_rd_addr];
    end
  end
  // RAM writes; host write is issued last so it wins an address collision
  always_ff @(posedge clk) begin
    if (r_state == S_ACK_WR && !rst) r_ram[r_a_q] <= bus.mem_data_out;
    if (bus.host_we) r_ram[bus.host_addr] <= bus.host_wdata;
  end
  assign bus.mem_data_in      = r_data_in;
  assign bus.mem_enable_read  = (r_state == S_ACK_RD);
  assign bus.mem_enable_write = (r_state == S_ACK_WR);
  assign bus.busy             = (r_state != S_IDLE);
endmodule
